// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-edge ops plus an iterative shift-add multiply,
// with the result and {C,V,N,Z} flags held until the consumer takes them.
module seq_alu #(
    parameter int DATA_W    = 16,
    parameter int ALUCTRL_W = 4,
    parameter bit MUL_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALUCTRL_W-1:0] aluctrl,
    input  logic [DATA_W-1:0]    data1,
    input  logic [DATA_W-1:0]    data2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    aluout,
    output logic [3:0]           flags
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ALUCTRL_W-1:0] OP_ADD = ALUCTRL_W'(4'd1);
    localparam logic [ALUCTRL_W-1:0] OP_AND = ALUCTRL_W'(4'd2);
    localparam logic [ALUCTRL_W-1:0] OP_XOR = ALUCTRL_W'(4'd3);
    localparam logic [ALUCTRL_W-1:0] OP_OR  = ALUCTRL_W'(4'd4);
    localparam logic [ALUCTRL_W-1:0] OP_NOT = ALUCTRL_W'(4'd5);
    localparam logic [ALUCTRL_W-1:0] OP_SHL = ALUCTRL_W'(4'd6);
    localparam logic [ALUCTRL_W-1:0] OP_SHR = ALUCTRL_W'(4'd7);
    localparam logic [ALUCTRL_W-1:0] OP_SUB = ALUCTRL_W'(4'd8);
    localparam logic [ALUCTRL_W-1:0] OP_SRA = ALUCTRL_W'(4'd9);
    localparam logic [ALUCTRL_W-1:0] OP_MUL = ALUCTRL_W'(4'd10);
    localparam logic [ALUCTRL_W-1:0] OP_CMP = ALUCTRL_W'(4'd11);

    localparam int                CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] DW_V      = DATA_W'(DATA_W);

    logic [1:0]          state_r;
    logic [1:0]          state_next_s;
    logic                accept_s;
    logic                is_mul_s;
    logic [DATA_W-1:0]   aluout_r;
    logic [3:0]          flags_r;
    logic [DATA_W-1:0]   a_r;
    logic [2*DATA_W-1:0] prod_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [DATA_W:0]     sum_s;
    logic [DATA_W:0]     diff_s;
    logic [DATA_W:0]     shl_s;
    logic [DATA_W:0]     shr_s;
    logic [DATA_W:0]     sra_s;
    logic [DATA_W-1:0]   res_s;
    logic [DATA_W-1:0]   nzv_s;
    logic                c_s;
    logic                v_s;
    logic [3:0]          flg_s;

    logic [DATA_W:0]     madd_s;
    logic [2*DATA_W:0]   pwide_s;
    logic [2*DATA_W-1:0] pnext_s;

    assign accept_s = in_valid && (state_r == ST_IDLE);
    assign is_mul_s = MUL_EN && (aluctrl == OP_MUL);
    assign aluout   = aluout_r;
    assign flags    = flags_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = is_mul_s ? ST_MUL : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == LAST_STEP) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Single-edge result and flags; carry of the wide shifts is the last bit shifted out
    always_comb begin
        sum_s  = {1'b0, data1} + {1'b0, data2};
        diff_s = {1'b0, data1} + {1'b0, ~data2} + {{DATA_W{1'b0}}, 1'b1};
        shl_s  = {1'b0, data1} << data2;
        shr_s  = {data1, 1'b0} >> data2;
        sra_s  = $signed({data1, 1'b0}) >>> data2;
        res_s  = data1;
        c_s    = 1'b0;
        v_s    = 1'b0;
        nzv_s  = {DATA_W{1'b0}};
        case (aluctrl)
            OP_ADD: begin
                res_s = sum_s[DATA_W-1:0];
                c_s   = sum_s[DATA_W];
                v_s   = (data1[DATA_W-1] == data2[DATA_W-1]) && (sum_s[DATA_W-1] != data1[DATA_W-1]);
            end
            OP_AND: res_s = data1 & data2;
            OP_XOR: res_s = data1 ^ data2;
            OP_OR:  res_s = data1 | data2;
            OP_NOT: res_s = ~data1;
            OP_SHL: begin
                res_s = shl_s[DATA_W-1:0];
                c_s   = shl_s[DATA_W];
            end
            OP_SHR: begin
                res_s = shr_s[DATA_W:1];
                c_s   = shr_s[0];
            end
            OP_SRA: begin
                res_s = sra_s[DATA_W:1];
                c_s   = (data2 > DW_V) ? 1'b0 : sra_s[0];
            end
            OP_SUB, OP_CMP: begin
                res_s = (aluctrl == OP_CMP) ? data1 : diff_s[DATA_W-1:0];
                c_s   = diff_s[DATA_W];
                v_s   = (data1[DATA_W-1] != data2[DATA_W-1]) && (diff_s[DATA_W-1] != data1[DATA_W-1]);
            end
            default: res_s = data1;
        endcase
        if (aluctrl == OP_CMP) begin
            nzv_s = diff_s[DATA_W-1:0];
        end else begin
            nzv_s = res_s;
        end
        flg_s = {c_s, v_s, nzv_s[DATA_W-1], (nzv_s == {DATA_W{1'b0}})};
    end

    // One shift-add multiply step: add A into the high half on multiplier LSB, shift right
    always_comb begin
        madd_s  = {1'b0, prod_r[2*DATA_W-1:DATA_W]} + (prod_r[0] ? {1'b0, a_r} : {(DATA_W+1){1'b0}});
        pwide_s = {madd_s, prod_r[DATA_W-1:0]};
        pnext_s = pwide_s[2*DATA_W:1];
    end

    // Datapath registers: operand latch, multiply accumulator, result and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout_r <= {DATA_W{1'b0}};
            flags_r  <= 4'd0;
            a_r      <= {DATA_W{1'b0}};
            prod_r   <= {(2*DATA_W){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        a_r    <= data1;
                        prod_r <= {{DATA_W{1'b0}}, data2};
                        cnt_r  <= {CNT_W{1'b0}};
                    end else if (accept_s) begin
                        aluout_r <= res_s;
                        flags_r  <= flg_s;
                    end else begin
                        aluout_r <= aluout_r;
                    end
                end
                ST_MUL: begin
                    prod_r <= pnext_s;
                    cnt_r  <= cnt_r + CNT_W'(1'b1);
                    if (cnt_r == LAST_STEP) begin
                        aluout_r <= pnext_s[DATA_W-1:0];
                        flags_r  <= {(pnext_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}}), 1'b0,
                                     pnext_s[DATA_W-1], (pnext_s[DATA_W-1:0] == {DATA_W{1'b0}})};
                    end else begin
                        flags_r <= flags_r;
                    end
                end
                default: begin
                    aluout_r <= aluout_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at default parameters (16-bit data, MUL enabled).
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluctrl;
    logic [15:0] data1;
    logic [15:0] data2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] aluout;
    logic [3:0]  flags;

    int nvec;
    int nerr;

    seq_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctrl   (aluctrl),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluout    (aluout),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Issue one op, measure edges from accept (inclusive) to out_valid, check result, then consume.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_out,
                          input logic [3:0] exp_flg, input int exp_lat);
        int lat;
        logic rdy_seen;
        @(negedge clk);
        aluctrl  = op;
        data1    = a;
        data2    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        aluctrl  = 4'd1;
        data1    = 16'hDEAD;
        data2    = 16'hBEEF;
        lat      = 1;
        rdy_seen = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk_eq({tag, "_lat"}, lat, exp_lat);
        chk_eq({tag, "_out"}, aluout, exp_out);
        chk_eq({tag, "_flg"}, flags, exp_flg);
        chk_eq({tag, "_rdy"}, rdy_seen, 1'b0);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] held_out;
        logic [3:0]  held_flg;
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluctrl   = 4'd0;
        data1     = 16'h0000;
        data2     = 16'h0000;
        #12;
        chk_eq("rst_rdy", in_ready, 1'b1);
        chk_eq("rst_ov", out_valid, 1'b0);
        chk_eq("rst_out", aluout, 16'h0000);
        chk_eq("rst_flg", flags, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // flags are {C,V,N,Z}
        run_op("add_wrap", 4'd1,  16'hFFFF, 16'h0001, 16'h0000, 4'b1001, 1);
        run_op("add_ovf",  4'd1,  16'h7FFF, 16'h0001, 16'h8000, 4'b0110, 1);
        run_op("sub_ovf",  4'd8,  16'h8000, 16'h0001, 16'h7FFF, 4'b1100, 1);
        run_op("sub_brw",  4'd8,  16'h0000, 16'h0001, 16'hFFFF, 4'b0010, 1);
        run_op("cmp_lt",   4'd11, 16'h0005, 16'h0007, 16'h0005, 4'b0010, 1);
        run_op("cmp_eq",   4'd11, 16'h0007, 16'h0007, 16'h0007, 4'b1001, 1);
        run_op("mul_a",    4'd10, 16'h0123, 16'h0010, 16'h1230, 4'b0000, 17);
        run_op("mul_hi",   4'd10, 16'h0100, 16'h0100, 16'h0000, 4'b1001, 17);
        run_op("shl_1",    4'd6,  16'h8001, 16'h0001, 16'h0002, 4'b1000, 1);
        run_op("sra_20",   4'd9,  16'h8000, 16'd20,   16'hFFFF, 4'b0010, 1);
        run_op("shr_0",    4'd7,  16'h1234, 16'h0000, 16'h1234, 4'b0000, 1);
        run_op("shr_16",   4'd7,  16'h8001, 16'd16,   16'h0000, 4'b1001, 1);
        run_op("not",      4'd5,  16'h00FF, 16'h0000, 16'hFF00, 4'b0010, 1);
        run_op("xor",      4'd3,  16'hA5A5, 16'hFFFF, 16'h5A5A, 4'b0000, 1);
        run_op("and",      4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1);
        run_op("or",       4'd4,  16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1);
        run_op("undef",    4'd15, 16'h1234, 16'h5678, 16'h1234, 4'b0000, 1);

        // Hold in DONE with out_ready low while in_valid toggles
        @(negedge clk);
        aluctrl  = 4'd1;
        data1    = 16'h0001;
        data2    = 16'h0002;
        in_valid = 1'b1;
        @(posedge clk);
        held_out = 16'h0003;
        held_flg = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            aluctrl  = 4'd5;
            data1    = 16'h1111 * 16'(i + 1);
            chk_eq("hold_ov", out_valid, 1'b1);
            chk_eq("hold_rdy", in_ready, 1'b0);
            chk_eq("hold_out", aluout, held_out);
            chk_eq("hold_flg", flags, held_flg);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk_eq("rel_ov", out_valid, 1'b0);
        chk_eq("rel_rdy", in_ready, 1'b1);

        // Reset in the middle of a multiply
        @(negedge clk);
        aluctrl  = 4'd10;
        data1    = 16'h00FF;
        data2    = 16'h00FF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk_eq("mulrst_busy", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_eq("mulrst_ov", out_valid, 1'b0);
        chk_eq("mulrst_rdy", in_ready, 1'b1);
        chk_eq("mulrst_out", aluout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_post", 4'd1, 16'h0003, 16'h0004, 16'h0007, 4'b0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
